// File: rtl/core_package.sv
// Shared types for the decode-stage hazard scoreboard.
package core_package;

   localparam int REG_IDX_W = 5;
   localparam int CNT_W     = 4;

   typedef enum logic [2:0] {
      HZ_NONE    = 3'd0,
      HZ_RAW_RS1 = 3'd1,
      HZ_RAW_RS2 = 3'd2,
      HZ_WAW     = 3'd3,
      HZ_FULL    = 3'd4
   } hazard_cause_e;

endpackage

// File: rtl/sb_credit_counter.sv
// Up/down outstanding-op counter: saturates at 0 and MAX_COUNT, sync clear wins.
module sb_credit_counter
   import core_package::*;
#(
   parameter int MAX_COUNT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_i,
   input  logic             dec_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

   logic [CNT_W-1:0] count_q, count_d;

   // Simultaneous inc and dec cancel, so a same-cycle issue/release keeps the count.
   always_comb begin
      count_d = count_q;
      if (clr_i)
         count_d = '0;
      else if (inc_i && !dec_i && (count_q != MAX_C))
         count_d = count_q + 1'b1;
      else if (dec_i && !inc_i && (count_q != '0))
         count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count_o = count_q;
   assign full_o  = (count_q == MAX_C);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage issue scoreboard for long-latency ops (loads, MUL/DIV).
// HAZARD_PERF_CNT_EN adds a saturating stall-cycle counter on stall_cycles_o.
module hazard_scoreboard
   import core_package::*;
#(
   parameter int NUM_REGS        = 32,
   parameter int MAX_OUTSTANDING = 4
`ifdef HAZARD_PERF_CNT_EN
   ,parameter int PERF_W         = 32
`endif
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 dec_valid_i,
   input  logic [REG_IDX_W-1:0] dec_rs1_i,
   input  logic [REG_IDX_W-1:0] dec_rs2_i,
   input  logic [REG_IDX_W-1:0] dec_rd_i,
   input  logic                 dec_use_rs1_i,
   input  logic                 dec_use_rs2_i,
   input  logic                 dec_wr_rd_i,
   input  logic                 dec_long_i,
   input  logic                 wb_valid_i,
   input  logic [REG_IDX_W-1:0] wb_rd_i,
   input  logic                 flush_i,
   output logic                 stall_o,
   output hazard_cause_e        stall_cause_o,
   output logic [NUM_REGS-1:0]  pending_o,
   output logic [CNT_W-1:0]     outstanding_o,
   output logic                 sb_error_o
`ifdef HAZARD_PERF_CNT_EN
   ,output logic [PERF_W-1:0]   stall_cycles_o
`endif
);

   logic [NUM_REGS-1:0] pending_q, pending_d;
   logic                sb_error_q, sb_error_d;
   logic                cnt_full;
   logic                busy_rs1, busy_rs2, busy_rd;
   logic                raw1, raw2, waw, full_hz;
   logic                issue, set_en, wb_hit, wb_err;

   // A writeback landing this cycle releases its register immediately (bypass).
   assign busy_rs1 = pending_q[dec_rs1_i] && !(wb_valid_i && (wb_rd_i == dec_rs1_i));
   assign busy_rs2 = pending_q[dec_rs2_i] && !(wb_valid_i && (wb_rd_i == dec_rs2_i));
   assign busy_rd  = pending_q[dec_rd_i]  && !(wb_valid_i && (wb_rd_i == dec_rd_i));

   assign raw1    = dec_use_rs1_i && busy_rs1;
   assign raw2    = dec_use_rs2_i && busy_rs2;
   assign waw     = dec_wr_rd_i   && busy_rd;
   assign full_hz = dec_long_i && cnt_full && !wb_valid_i;

   assign stall_o = dec_valid_i && !flush_i && (raw1 || raw2 || waw || full_hz);

   always_comb begin
      stall_cause_o = HZ_NONE;
      if (stall_o) begin
         if (raw1)      stall_cause_o = HZ_RAW_RS1;
         else if (raw2) stall_cause_o = HZ_RAW_RS2;
         else if (waw)  stall_cause_o = HZ_WAW;
         else           stall_cause_o = HZ_FULL;
      end
   end

   assign issue  = dec_valid_i && !stall_o && !flush_i;
   assign set_en = issue && dec_long_i && dec_wr_rd_i && (dec_rd_i != '0);
   assign wb_hit = wb_valid_i && !flush_i && pending_q[wb_rd_i];
   assign wb_err = wb_valid_i && !flush_i && !pending_q[wb_rd_i];

   // Clear before set so a same-register issue/release leaves the bit pending.
   always_comb begin
      pending_d  = pending_q;
      sb_error_d = sb_error_q || wb_err;
      if (wb_hit) pending_d[wb_rd_i]  = 1'b0;
      if (set_en) pending_d[dec_rd_i] = 1'b1;
      if (flush_i) pending_d = '0;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending_q  <= '0;
         sb_error_q <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         sb_error_q <= sb_error_d;
      end
   end

   sb_credit_counter #(
      .MAX_COUNT (MAX_OUTSTANDING)
   ) u_credit (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (set_en),
      .dec_i   (wb_hit),
      .clr_i   (flush_i),
      .count_o (outstanding_o),
      .full_o  (cnt_full)
   );

   assign pending_o  = pending_q;
   assign sb_error_o = sb_error_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [PERF_W-1:0] stall_cycles_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         stall_cycles_q <= '0;
      else if (stall_o && (stall_cycles_q != '1))
         stall_cycles_q <= stall_cycles_q + 1'b1;
   end

   assign stall_cycles_o = stall_cycles_q;
`endif

endmodule
